// File: rtl/dm.sv
// Debug-module DMI payload types shared by the DMI arbiter and its users.
package dm;

  localparam int unsigned DMI_ADDR_W = 7;
  localparam int unsigned DMI_OP_W   = 2;
  localparam int unsigned DMI_DATA_W = 32;

  localparam logic [DMI_OP_W-1:0] DMI_OP_SUCCESS = 2'd0;
  localparam logic [DMI_OP_W-1:0] DMI_OP_FAILED  = 2'd2;

  typedef struct packed {
    logic [DMI_ADDR_W-1:0] addr;
    logic [DMI_OP_W-1:0]   op;
    logic [DMI_DATA_W-1:0] data;
  } dmi_req_t;

  typedef struct packed {
    logic [DMI_DATA_W-1:0] data;
    logic [DMI_OP_W-1:0]   resp;
  } dmi_resp_t;

endpackage

// File: rtl/dmi_arbiter.sv
// Round-robin arbiter sharing one debug-module DMI port between several
// requesters, one transaction in flight, with a response timeout.
module dmi_arbiter #(
  parameter int unsigned NR_MASTERS     = 2,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  dm::dmi_req_t          mst_req_i        [NR_MASTERS],
  input  logic [NR_MASTERS-1:0] mst_valid_i,
  output logic [NR_MASTERS-1:0] mst_ready_o,
  output dm::dmi_resp_t         mst_resp_o       [NR_MASTERS],
  output logic [NR_MASTERS-1:0] mst_resp_valid_o,
  input  logic [NR_MASTERS-1:0] mst_resp_ready_i,
  output dm::dmi_req_t          slv_req_o,
  output logic                  slv_valid_o,
  input  logic                  slv_ready_i,
  input  dm::dmi_resp_t         slv_resp_i,
  input  logic                  slv_resp_valid_i,
  output logic                  slv_resp_ready_o
);

  localparam int unsigned IDX_W = (NR_MASTERS > 2) ? 2 : 1;
  localparam int unsigned CNT_W = 16;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [IDX_W-1:0] prio_q, prio_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             stale_q, stale_d;
  dm::dmi_req_t     req_q, req_d;
  dm::dmi_resp_t    resp_q, resp_d;

  logic             gnt_found;
  logic [IDX_W-1:0] gnt_idx;
  logic [IDX_W-1:0] cand_idx;

  // Round-robin pick: first valid requester at or after prio_q.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand_idx  = '0;
    for (int unsigned i = 0; i < NR_MASTERS; i++) begin
      cand_idx = IDX_W'((32'(prio_q) + i) % NR_MASTERS);
      if (!gnt_found && mst_valid_i[cand_idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand_idx;
      end
    end
  end

  // Next-state and output decode for the single-outstanding transaction FSM.
  always_comb begin
    state_d          = state_q;
    prio_d           = prio_q;
    owner_d          = owner_q;
    cnt_d            = cnt_q;
    stale_d          = stale_q;
    req_d            = req_q;
    resp_d           = resp_q;
    mst_ready_o      = '0;
    mst_resp_valid_o = '0;
    for (int unsigned i = 0; i < NR_MASTERS; i++) begin
      mst_resp_o[i] = '0;
    end
    slv_req_o        = req_q;
    slv_valid_o      = 1'b0;
    slv_resp_ready_o = stale_q;

    // A late response after a timeout is swallowed here, never forwarded.
    if (state_q != WAIT && stale_q && slv_resp_valid_i) begin
      stale_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        // No grant while a late response may still arrive, and none in reset.
        if (gnt_found && !stale_q && !rst_i) begin
          mst_ready_o[gnt_idx] = 1'b1;
          req_d                = mst_req_i[gnt_idx];
          owner_d              = gnt_idx;
          prio_d               = IDX_W'((32'(gnt_idx) + 32'd1) % NR_MASTERS);
          state_d              = REQ;
        end
      end
      REQ: begin
        slv_valid_o = 1'b1;
        if (slv_ready_i) begin
          cnt_d   = '0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        slv_resp_ready_o = 1'b1;
        cnt_d            = cnt_q + CNT_W'(1);
        // The real response wins over a coincident timeout.
        if (slv_resp_valid_i) begin
          resp_d  = slv_resp_i;
          cnt_d   = '0;
          state_d = RESP;
        end else if (cnt_q == CNT_LAST) begin
          resp_d.data = '0;
          resp_d.resp = dm::DMI_OP_FAILED;
          stale_d     = 1'b1;
          cnt_d       = '0;
          state_d     = RESP;
        end
      end
      RESP: begin
        mst_resp_valid_o[owner_q] = 1'b1;
        mst_resp_o[owner_q]       = resp_q;
        if (mst_resp_ready_i[owner_q]) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with asynchronous reset abandoning any transaction.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      prio_q  <= '0;
      owner_q <= '0;
      cnt_q   <= '0;
      stale_q <= 1'b0;
      req_q   <= '0;
      resp_q  <= '0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      stale_q <= stale_d;
      req_q   <= req_d;
      resp_q  <= resp_d;
    end
  end

endmodule

// File: tb/tb_dmi_arbiter.sv
// Self-checking bench for dmi_arbiter: directed scenarios plus random traffic
// compared against a transaction-level model of arbitration and timeout.
module tb_dmi_arbiter;

  localparam int unsigned NR = 2;
  localparam int unsigned TO = 8;

  logic            clk_i = 1'b0;
  logic            rst_i = 1'b0;
  dm::dmi_req_t    mst_req_i        [NR];
  logic [NR-1:0]   mst_valid_i      = '0;
  logic [NR-1:0]   mst_ready_o;
  dm::dmi_resp_t   mst_resp_o       [NR];
  logic [NR-1:0]   mst_resp_valid_o;
  logic [NR-1:0]   mst_resp_ready_i = '0;
  dm::dmi_req_t    slv_req_o;
  logic            slv_valid_o;
  logic            slv_ready_i      = 1'b0;
  dm::dmi_resp_t   slv_resp_i       = '0;
  logic            slv_resp_valid_i = 1'b0;
  logic            slv_resp_ready_o;

  int checks   = 0;
  int failures = 0;

  // Model state: next round-robin start and whether a late response is owed.
  int m_prio  = 0;
  bit m_stale = 1'b0;

  dmi_arbiter #(.NR_MASTERS(NR), .TIMEOUT_CYCLES(TO)) dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .mst_req_i        (mst_req_i),
    .mst_valid_i      (mst_valid_i),
    .mst_ready_o      (mst_ready_o),
    .mst_resp_o       (mst_resp_o),
    .mst_resp_valid_o (mst_resp_valid_o),
    .mst_resp_ready_i (mst_resp_ready_i),
    .slv_req_o        (slv_req_o),
    .slv_valid_o      (slv_valid_o),
    .slv_ready_i      (slv_ready_i),
    .slv_resp_i       (slv_resp_i),
    .slv_resp_valid_i (slv_resp_valid_i),
    .slv_resp_ready_o (slv_resp_ready_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic dm::dmi_req_t rand_req();
    dm::dmi_req_t r;
    r.addr = 7'($urandom);
    r.op   = 2'($urandom);
    r.data = $urandom;
    return r;
  endfunction

  task automatic apply_reset();
    @(negedge clk_i);
    rst_i            = 1'b1;
    mst_valid_i      = '0;
    mst_resp_ready_i = '0;
    slv_ready_i      = 1'b0;
    slv_resp_valid_i = 1'b0;
    @(negedge clk_i);
    rst_i   = 1'b0;
    m_prio  = 0;
    m_stale = 1'b0;
  endtask

  // One full transaction, checked phase by phase against the model.
  task automatic do_txn(input logic [NR-1:0] mask, input bit use_fixed,
                        input dm::dmi_req_t fixed_req, input int rdy_dly,
                        input int resp_dly, input int mrdy_dly,
                        input dm::dmi_resp_t sresp, input bit rst_in_wait,
                        output int obs_g);
    dm::dmi_req_t  reqs [NR];
    dm::dmi_req_t  exp_req;
    dm::dmi_resp_t exp_resp;
    logic [NR-1:0] own;
    int            g;
    bit            timed_out;

    for (int i = 0; i < NR; i++) reqs[i] = use_fixed ? fixed_req : rand_req();
    g = -1;
    for (int i = 0; i < NR; i++) begin
      int c;
      c = (m_prio + i) % NR;
      if (g < 0 && mask[c]) g = c;
    end
    own = NR'(1) << g;

    // Grant cycle
    @(negedge clk_i);
    mst_valid_i      = mask;
    for (int i = 0; i < NR; i++) mst_req_i[i] = reqs[i];
    slv_ready_i      = 1'b0;
    slv_resp_valid_i = 1'b0;
    mst_resp_ready_i = '0;
    #1;
    obs_g = -1;
    for (int i = 0; i < NR; i++) if (mst_ready_o[i]) obs_g = i;
    checks++;
    if (mst_ready_o !== own) begin
      failures++;
      $display("FAIL grant: mst_ready_o=%b expected=%b", mst_ready_o, own);
    end
    exp_req = reqs[g];
    m_prio  = (g + 1) % NR;

    // Request phase: captured request held while the slave stalls
    for (int k = 0; k <= rdy_dly; k++) begin
      @(negedge clk_i);
      mst_valid_i  = mask & ~own;
      mst_req_i[g] = rand_req();
      slv_ready_i  = (k == rdy_dly);
      #1;
      checks++;
      if (slv_valid_o !== 1'b1 || slv_req_o !== exp_req || mst_ready_o !== '0 ||
          mst_resp_valid_o !== '0) begin
        failures++;
        $display("FAIL req_phase k=%0d: valid=%b req=%h rdy=%b rv=%b expected valid=1 req=%h",
                 k, slv_valid_o, slv_req_o, mst_ready_o, mst_resp_valid_o, exp_req);
      end
    end

    // Wait phase: response or timeout
    timed_out = 1'b0;
    for (int k = 0; k < int'(TO); k++) begin
      @(negedge clk_i);
      slv_ready_i = 1'b0;
      if (rst_in_wait && k == 1) begin
        slv_resp_valid_i = 1'b0;
        mst_valid_i      = '1;
        rst_i            = 1'b1;
        #1;
        checks++;
        if (mst_ready_o !== '0 || slv_valid_o !== 1'b0 || slv_resp_ready_o !== 1'b0 ||
            mst_resp_valid_o !== '0 || slv_req_o !== '0) begin
          failures++;
          $display("FAIL reset_in_wait: rdy=%b sv=%b srr=%b rv=%b req=%h expected all 0",
                   mst_ready_o, slv_valid_o, slv_resp_ready_o, mst_resp_valid_o, slv_req_o);
        end
        @(negedge clk_i);
        rst_i       = 1'b0;
        mst_valid_i = '0;
        m_prio      = 0;
        m_stale     = 1'b0;
        @(negedge clk_i);
        #1;
        checks++;
        if (mst_resp_valid_o !== '0 || slv_valid_o !== 1'b0) begin
          failures++;
          $display("FAIL reset_abandon: rv=%b sv=%b expected 0 0", mst_resp_valid_o, slv_valid_o);
        end
        return;
      end
      slv_resp_valid_i = (k == resp_dly);
      slv_resp_i       = sresp;
      #1;
      checks++;
      if (slv_valid_o !== 1'b0 || slv_resp_ready_o !== 1'b1 || mst_resp_valid_o !== '0) begin
        failures++;
        $display("FAIL wait_phase k=%0d: sv=%b srr=%b rv=%b expected 0 1 0",
                 k, slv_valid_o, slv_resp_ready_o, mst_resp_valid_o);
      end
      if (k == resp_dly) break;
      if (k == int'(TO) - 1) timed_out = 1'b1;
    end
    if (timed_out) begin
      exp_resp.data = '0;
      exp_resp.resp = dm::DMI_OP_FAILED;
      m_stale       = 1'b1;
    end else begin
      exp_resp = sresp;
    end

    // Response phase: held for the owner until it accepts
    for (int k = 0; k <= mrdy_dly; k++) begin
      @(negedge clk_i);
      slv_resp_valid_i = 1'b0;
      mst_resp_ready_i = (NR'($urandom) & ~own) | ((k == mrdy_dly) ? own : '0);
      #1;
      checks++;
      if (mst_resp_valid_o !== own || mst_resp_o[g] !== exp_resp ||
          slv_resp_ready_o !== m_stale || slv_valid_o !== 1'b0) begin
        failures++;
        $display("FAIL resp_phase k=%0d: rv=%b resp=%h srr=%b expected rv=%b resp=%h srr=%b",
                 k, mst_resp_valid_o, mst_resp_o[g], slv_resp_ready_o, own, exp_resp, m_stale);
      end
    end
  endtask

  // After a timeout: no grants until the late response is drained.
  task automatic drain_stale(input logic [NR-1:0] mask);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_i);
      mst_valid_i      = mask;
      mst_resp_ready_i = '0;
      slv_resp_valid_i = 1'b0;
      #1;
      checks++;
      if (mst_ready_o !== '0 || slv_resp_ready_o !== 1'b1) begin
        failures++;
        $display("FAIL stale_block: rdy=%b srr=%b expected 0 1", mst_ready_o, slv_resp_ready_o);
      end
    end
    @(negedge clk_i);
    slv_resp_valid_i = 1'b1;
    slv_resp_i       = {$urandom, 2'($urandom)};
    #1;
    checks++;
    if (mst_ready_o !== '0 || mst_resp_valid_o !== '0) begin
      failures++;
      $display("FAIL stale_drain: rdy=%b rv=%b expected 0 0", mst_ready_o, mst_resp_valid_o);
    end
    m_stale = 1'b0;
  endtask

  task automatic test_reset();
    rst_i       = 1'b1;
    mst_valid_i = '1;
    #2;
    checks++;
    if (mst_ready_o !== '0 || slv_valid_o !== 1'b0 || slv_resp_ready_o !== 1'b0 ||
        mst_resp_valid_o !== '0 || slv_req_o !== '0) begin
      failures++;
      $display("FAIL reset: rdy=%b sv=%b srr=%b rv=%b req=%h expected all 0",
               mst_ready_o, slv_valid_o, slv_resp_ready_o, mst_resp_valid_o, slv_req_o);
    end
    apply_reset();
  endtask

  task automatic test_single_read();
    dm::dmi_req_t  r;
    dm::dmi_resp_t s;
    int            g;
    r.addr = 7'h11; r.op = 2'd1; r.data = '0;
    s.data = 32'hDEADBEEF; s.resp = 2'd0;
    do_txn(2'b01, 1'b1, r, 0, 3, 0, s, 1'b0, g);
    checks++;
    if (g !== 0) begin
      failures++;
      $display("FAIL single_read_owner: got=%0d expected=0", g);
    end
  endtask

  task automatic test_contention();
    int exp_seq [4] = '{0, 1, 0, 1};
    int g;
    apply_reset();
    for (int t = 0; t < 4; t++) begin
      do_txn(2'b11, 1'b0, '0, 0, 1, 0, {$urandom, 2'd0}, 1'b0, g);
      checks++;
      if (g !== exp_seq[t]) begin
        failures++;
        $display("FAIL contention_order t=%0d: got=%0d expected=%0d", t, g, exp_seq[t]);
      end
    end
  endtask

  task automatic test_timeout();
    int g;
    do_txn(2'b01, 1'b0, '0, 0, 1000, 2, '0, 1'b0, g);
    drain_stale(2'b11);
    do_txn(2'b11, 1'b0, '0, 0, 0, 0, {$urandom, 2'd0}, 1'b0, g);
  endtask

  task automatic test_backpressure();
    int g;
    do_txn(2'b10, 1'b0, '0, 5, 2, 4, {$urandom, 2'd3}, 1'b0, g);
  endtask

  task automatic test_simultaneous();
    int g;
    do_txn(2'b11, 1'b0, '0, 0, int'(TO) - 1, 1, {32'hCAFEF00D, 2'd0}, 1'b0, g);
    do_txn(2'b11, 1'b0, '0, 0, 0, 0, {$urandom, 2'd0}, 1'b0, g);
  endtask

  task automatic test_reset_in_wait();
    int g;
    do_txn(2'b11, 1'b0, '0, 0, 5, 0, {$urandom, 2'd0}, 1'b1, g);
    do_txn(2'b11, 1'b0, '0, 1, 2, 1, {$urandom, 2'd0}, 1'b0, g);
    checks++;
    if (g !== 0) begin
      failures++;
      $display("FAIL post_reset_owner: got=%0d expected=0", g);
    end
  endtask

  task automatic test_random();
    int g;
    for (int t = 0; t < 30; t++) begin
      do_txn(NR'($urandom_range(1, 3)), 1'b0, '0, int'($urandom_range(0, 3)),
             int'($urandom_range(0, 9)), int'($urandom_range(0, 3)),
             {$urandom, 2'($urandom)}, 1'b0, g);
      if (m_stale) drain_stale(NR'($urandom));
    end
  endtask

  initial begin
    for (int i = 0; i < NR; i++) mst_req_i[i] = '0;
    test_reset();
    test_single_read();
    test_contention();
    test_timeout();
    test_backpressure();
    test_simultaneous();
    test_reset_in_wait();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
